// File: rtl/spm_pkg.sv
// Shared definitions for the RISC_SPM program loader, RAM and core.
// Holds the stream/RAM widths, frame constants and loader state encoding.
package spm_pkg;

    localparam int SPM_ADDR_W    = 8;
    localparam int SPM_DATA_W    = 8;
    localparam int SPM_RAM_DEPTH = 1 << SPM_ADDR_W;

    localparam logic [SPM_DATA_W-1:0] SPM_SYNC_BYTE = 8'hA5;
    localparam logic [SPM_DATA_W-1:0] SPM_GO_BYTE   = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } spm_state_t;

endpackage

// File: rtl/spm_boot_ctr.sv
// Loadable down-counter shared by the frame byte count and the core reset hold delay.
// Load wins over decrement; decrement stops at zero.
module spm_boot_ctr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);
    assign last = (count_reg == W'(1));

endmodule

// File: rtl/spm_boot_loader.sv
// Framed byte-stream loader: writes program bytes into the SPM RAM and holds
// the core in reset until a GO command is accepted.
module spm_boot_loader
    import spm_pkg::*;
#(
    parameter int                ADDR_W    = SPM_ADDR_W,
    parameter int                DATA_W    = SPM_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SPM_SYNC_BYTE),
    parameter logic [DATA_W-1:0] GO_BYTE   = DATA_W'(SPM_GO_BYTE),
    parameter int                RST_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [7:0]        frame_cnt
);

    // One extra bit so a length byte of 0 can represent 256 bytes.
    localparam int CNT_W = DATA_W + 1;

    spm_state_t state_reg, state_next;

    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [7:0]        frame_cnt_reg, frame_cnt_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              in_ready_reg, in_ready_next;
    logic              cpu_rst_n_reg, cpu_rst_n_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              xfer;
    logic [DATA_W-1:0] csum_total;
    logic              ctr_load, ctr_dec, ctr_zero, ctr_last;
    logic [CNT_W-1:0]  ctr_load_val;

    assign xfer       = in_valid && in_ready_reg;
    assign csum_total = sum_reg + in_data;

    spm_boot_ctr #(
        .W(CNT_W)
    ) u_ctr (
        .clk     (clk),
        .srst    (rst),
        .load    (ctr_load),
        .load_val(ctr_load_val),
        .dec     (ctr_dec),
        .zero    (ctr_zero),
        .last    (ctr_last)
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        sum_next       = sum_reg;
        frame_cnt_next = frame_cnt_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ctr_load       = 1'b0;
        ctr_load_val   = '0;
        ctr_dec        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    if (in_data == SYNC_BYTE) begin
                        state_next = ST_ADDR;
                    end else if (in_data == GO_BYTE) begin
                        state_next   = ST_HOLD;
                        ctr_load     = 1'b1;
                        ctr_load_val = CNT_W'(RST_HOLD);
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_ADDR: begin
                if (xfer) begin
                    ptr_next   = ADDR_W'(in_data);
                    sum_next   = in_data;
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    ctr_load     = 1'b1;
                    ctr_load_val = (in_data == '0) ? CNT_W'(1 << DATA_W) : CNT_W'(in_data);
                    sum_next     = csum_total;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = ptr_reg;
                    mem_wdata_next = in_data;
                    ptr_next       = ptr_reg + 1'b1;
                    sum_next       = csum_total;
                    ctr_dec        = 1'b1;
                    if (ctr_last) begin
                        state_next = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (csum_total == '0) begin
                        state_next = ST_IDLE;
                        if (frame_cnt_reg != 8'hFF) begin
                            frame_cnt_next = frame_cnt_reg + 8'd1;
                        end
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end
            // Counter runs down to zero, giving RST_HOLD+1 cycles of hold after GO.
            ST_HOLD: begin
                if (ctr_zero) begin
                    state_next = ST_RUN;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_RUN:   state_next = ST_RUN;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase

        in_ready_next  = (state_next == ST_IDLE) || (state_next == ST_ADDR) ||
                         (state_next == ST_LEN)  || (state_next == ST_DATA) ||
                         (state_next == ST_CSUM);
        cpu_rst_n_next = (state_next == ST_RUN);
        done_next      = (state_next == ST_RUN);
        err_next       = (state_next == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            sum_reg       <= '0;
            frame_cnt_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            in_ready_reg  <= 1'b0;
            cpu_rst_n_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            sum_reg       <= sum_next;
            frame_cnt_reg <= frame_cnt_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            in_ready_reg  <= in_ready_next;
            cpu_rst_n_reg <= cpu_rst_n_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_rst_n = cpu_rst_n_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
